// File: rtl/adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// adc_scan_ctrl
//
// Scan sequencer for the AD7265 dual simultaneous-sampling ADC. It steps the
// mux address through 0..NUM_ADDR-1, frames each conversion with ncs and
// adc_sclk, and deserialises the A/B channel words into one result pair per
// conversion.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   enable     continuous scanning while high (checked only in IDLE and DONE)
//   cfg_rng    range select, latched at scan start and at each address wrap
//   cfg_sgl    single-ended/differential select, latched like cfg_rng
//   adc_sclk   ADC serial clock, idles high (registered)
//   ncs        ADC chip select, active low (registered)
//   rng, sgl   latched configuration driven to the ADC
//   adc_addr   mux address of the current conversion
//   douta      ADC serial data, channel A
//   doutb      ADC serial data, channel B
//   res_valid  one-cycle strobe, result fields are new
//   res_addr   address the result belongs to
//   res_a      12-bit channel A code
//   res_b      12-bit channel B code
//   scan_done  one-cycle strobe with the result for address NUM_ADDR-1
//   busy       high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module adc_scan_ctrl #(
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4,
    parameter int NUM_ADDR     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cfg_rng,
    input  logic        cfg_sgl,
    output logic        adc_sclk,
    output logic        ncs,
    output logic        rng,
    output logic        sgl,
    output logic [2:0]  adc_addr,
    input  logic        douta,
    input  logic        doutb,
    output logic        res_valid,
    output logic [2:0]  res_addr,
    output logic [11:0] res_a,
    output logic [11:0] res_b,
    output logic        scan_done,
    output logic        busy
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
    localparam logic [2:0]    ADDR_LAST  = 3'(NUM_ADDR - 1);

    typedef enum logic [1:0] {IDLE, QUIET, SHIFT, DONE} state_t;

    state_t        state;
    logic [QW-1:0] quiet_cnt;
    logic [DW-1:0] div_cnt;
    logic [4:0]    half;      // half-period index within the frame, 0..31
    logic [15:0]   sha;
    logic [15:0]   shb;
    logic          sample_now;

    function automatic logic [2:0] next_addr(input logic [2:0] a);
        return (a == ADDR_LAST) ? 3'd0 : a + 3'd1;
    endfunction

    // Even half-periods are the sclk-high ones; sample in their last cycle,
    // just before the falling edge that makes the ADC present the next bit.
    assign sample_now = (state == SHIFT) && !half[0] && (div_cnt == DIV_LAST);

    // The 16 samples fully overwrite the shift registers each frame, so they
    // need no reset; the visible result registers below are reset instead.
    always_ff @(posedge clk) begin
        if (sample_now) begin
            sha <= {sha[14:0], douta};
            shb <= {shb[14:0], doutb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            quiet_cnt <= '0;
            div_cnt   <= '0;
            half      <= '0;
            adc_sclk  <= 1'b1;
            ncs       <= 1'b1;
            rng       <= 1'b0;
            sgl       <= 1'b0;
            adc_addr  <= 3'd0;
            res_valid <= 1'b0;
            scan_done <= 1'b0;
            res_addr  <= 3'd0;
            res_a     <= 12'd0;
            res_b     <= 12'd0;
            busy      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    ncs      <= 1'b1;
                    adc_sclk <= 1'b1;
                    busy     <= 1'b0;
                    if (enable) begin
                        // adc_addr is kept: after reset it is 0, after an
                        // enable drop it already points at the next address.
                        rng       <= cfg_rng;
                        sgl       <= cfg_sgl;
                        quiet_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= QUIET;
                    end
                end
                QUIET: begin
                    if (quiet_cnt == QUIET_LAST) begin
                        ncs      <= 1'b0;
                        adc_sclk <= 1'b1;
                        div_cnt  <= '0;
                        half     <= '0;
                        state    <= SHIFT;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (half == 5'd31) begin
                            // Last half-period is sclk-low, so all 16 samples
                            // are already in sha/shb.
                            ncs       <= 1'b1;
                            adc_sclk  <= 1'b1;
                            res_valid <= 1'b1;
                            res_addr  <= adc_addr;
                            res_a     <= sha[13:2];
                            res_b     <= shb[13:2];
                            scan_done <= (adc_addr == ADDR_LAST);
                            state     <= DONE;
                        end else begin
                            half     <= half + 5'd1;
                            adc_sclk <= ~adc_sclk;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Address advances with ncs high, so it never moves
                    // inside a frame; re-enable resumes at the next address.
                    adc_addr <= next_addr(adc_addr);
                    if (enable) begin
                        if (adc_addr == ADDR_LAST) begin
                            rng <= cfg_rng;
                            sgl <= cfg_sgl;
                        end
                        quiet_cnt <= '0;
                        state     <= QUIET;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
module tb_adc_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, rst1;
    logic        enable, cfg_rng, cfg_sgl;
    logic        douta, doutb;
    logic        adc_sclk, ncs, rng, sgl, res_valid, scan_done, busy;
    logic [2:0]  adc_addr, res_addr;
    logic [11:0] res_a, res_b;

    logic        enable1 = 1'b1;
    logic        douta1 = 1'b0;
    logic        doutb1 = 1'b1;
    logic        cfg1 = 1'b1;
    logic        adc_sclk1, ncs1, rng1, sgl1, res_valid1, scan_done1, busy1;
    logic [2:0]  adc_addr1, res_addr1;
    logic [11:0] res_a1, res_b1;

    always #5 clk = ~clk;

    adc_scan_ctrl u_dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_rng(cfg_rng), .cfg_sgl(cfg_sgl),
        .adc_sclk(adc_sclk), .ncs(ncs), .rng(rng), .sgl(sgl), .adc_addr(adc_addr),
        .douta(douta), .doutb(doutb), .res_valid(res_valid), .res_addr(res_addr),
        .res_a(res_a), .res_b(res_b), .scan_done(scan_done), .busy(busy)
    );

    adc_scan_ctrl #(.CLK_DIV(1), .QUIET_CYCLES(1), .NUM_ADDR(6)) u_fast (
        .clk(clk), .rst(rst1), .enable(enable1), .cfg_rng(cfg1), .cfg_sgl(cfg1),
        .adc_sclk(adc_sclk1), .ncs(ncs1), .rng(rng1), .sgl(sgl1), .adc_addr(adc_addr1),
        .douta(douta1), .doutb(doutb1), .res_valid(res_valid1), .res_addr(res_addr1),
        .res_a(res_a1), .res_b(res_b1), .scan_done(scan_done1), .busy(busy1)
    );

    // ADC model: frame = 00, code[11:0], 00, other channel; a new bit after
    // every sclk falling edge while ncs is low.
    logic [11:0] din_a [8];
    logic [11:0] din_b [8];
    int          falls = 0;
    logic [31:0] fa, fb;

    always @(negedge adc_sclk or posedge ncs) begin
        if (ncs) falls = 0;
        else     falls = falls + 1;
    end

    always @* begin
        fa = {2'b00, din_a[adc_addr], 2'b00, 16'hC3C3};
        fb = {2'b00, din_b[adc_addr], 2'b00, 16'h3C3C};
        douta = (!ncs && falls < 16) ? fa[31 - falls] : 1'b0;
        doutb = (!ncs && falls < 16) ? fb[31 - falls] : 1'b0;
    end

    typedef struct {
        logic [2:0]  addr;
        logic [11:0] a;
        logic [11:0] b;
        logic        done;
    } exp_t;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] exp_a;
        logic [11:0] exp_b;
    } vec_t;

    exp_t       sbq [$];
    logic [2:0] exp_addr = 3'd0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < maxc);
        if (!res_valid) check("res_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_addr(input logic [2:0] k);
        int n;
        int tries = 0;
        do begin
            wait_valid(200, n);
            tries++;
        end while (res_addr !== k && tries < 10);
        if (res_addr !== k) check("wait_addr_timeout", 32'(res_addr), 32'(k));
    endtask

    task automatic wait_ncs_low();
        int n = 0;
        while (ncs !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ncs !== 1'b0) check("ncs_low_timeout", 32'(ncs), 32'd0);
    endtask

    // Scoreboard/monitor for the default-parameter instance.
    task automatic monitor_main();
        logic       p_ncs = 1'b1;
        logic       p_rng = 1'b0;
        logic [2:0] p_addr = 3'd0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (p_ncs && !ncs) begin
                    e.addr = exp_addr;
                    e.a    = din_a[exp_addr];
                    e.b    = din_b[exp_addr];
                    e.done = (exp_addr == 3'd5);
                    sbq.push_back(e);
                    exp_addr = (exp_addr == 3'd5) ? 3'd0 : exp_addr + 3'd1;
                end
                if (res_valid) begin
                    if (sbq.size() == 0) begin
                        check("sb_unexpected_result", 32'(res_addr), 32'hFFFF);
                    end else begin
                        e = sbq.pop_front();
                        check("sb_res_addr", 32'(res_addr), 32'(e.addr));
                        check("sb_res_a", 32'(res_a), 32'(e.a));
                        check("sb_res_b", 32'(res_b), 32'(e.b));
                        check("sb_scan_done", 32'(scan_done), 32'(e.done));
                    end
                end else if (scan_done) begin
                    check("scan_done_without_valid", 32'(scan_done), 32'd0);
                end
                if (!ncs && !p_ncs) check("addr_stable_in_frame", 32'(adc_addr), 32'(p_addr));
                if (rng !== p_rng) begin
                    check("rng_change_ncs", 32'(ncs), 32'd1);
                    check("rng_change_addr", 32'(adc_addr), 32'd0);
                end
            end
            p_ncs  = ncs;
            p_rng  = rng;
            p_addr = adc_addr;
        end
    endtask

    // Timing monitor for the CLK_DIV=1, QUIET_CYCLES=1 instance.
    task automatic monitor_fast();
        logic       p_ncs = 1'b1;
        logic       p_sclk = 1'b1;
        logic [2:0] p_addr = 3'd0;
        int         cyc = 0;
        int         last_fall = -1;
        int         nf = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst1) begin
                if (p_ncs && !ncs1) begin
                    if (last_fall >= 0) check("fast_frame_period", 32'(cyc - last_fall), 32'd34);
                    last_fall = cyc;
                    nf = 0;
                end
                if (!ncs1) begin
                    if (p_sclk && !adc_sclk1) nf++;
                    check("fast_busy_in_frame", 32'(busy1), 32'd1);
                    if (!p_ncs) check("fast_addr_stable", 32'(adc_addr1), 32'(p_addr));
                end
                if (!p_ncs && ncs1) check("fast_sclk_falls", 32'(nf), 32'd16);
                if (res_valid1) begin
                    check("fast_res_a", 32'(res_a1), 32'h000);
                    check("fast_res_b", 32'(res_b1), 32'hFFF);
                    check("fast_scan_done", 32'(scan_done1), 32'(res_addr1 == 3'd5));
                    check("fast_rng_sgl", {30'd0, rng1, sgl1}, 32'd3);
                end
            end
            p_ncs  = ncs1;
            p_sclk = adc_sclk1;
            p_addr = adc_addr1;
        end
    endtask

    initial begin
        vec_t vecs [4];
        int   n;
        int   bad;

        vecs[0] = '{a: 12'hFFF, b: 12'h000, exp_a: 12'hFFF, exp_b: 12'h000};
        vecs[1] = '{a: 12'h000, b: 12'hFFF, exp_a: 12'h000, exp_b: 12'hFFF};
        vecs[2] = '{a: 12'hA5A, b: 12'h5A5, exp_a: 12'hA5A, exp_b: 12'h5A5};
        vecs[3] = '{a: 12'h001, b: 12'h800, exp_a: 12'h001, exp_b: 12'h800};

        rst = 1'b1; rst1 = 1'b1; enable = 1'b0; cfg_rng = 1'b0; cfg_sgl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din_a[i] = 12'h100 + 12'(i);
            din_b[i] = 12'h800 + 12'(i);
        end

        fork
            monitor_main();
            monitor_fast();
        join_none

        repeat (3) @(negedge clk);
        check("rst_ncs", 32'(ncs), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid_done", {30'd0, res_valid, scan_done}, 32'd0);
        check("rst_rng_sgl_addr", {27'd0, rng, sgl, adc_addr}, 32'd0);
        check("rst_results", {5'd0, res_addr, res_a, res_b}, 32'd0);
        rst = 1'b0; rst1 = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ncs", 32'(ncs), 32'd1);

        // Continuous scan of all six addresses with distinct codes.
        cfg_sgl = 1'b1;
        enable  = 1'b1;
        n = 0;
        while (ncs === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_ncs_fall_latency", 32'(n), 32'd5);
        check("sgl_latched", 32'(sgl), 32'd1);
        check("busy_running", 32'(busy), 32'd1);
        wait_valid(200, n);
        for (int i = 1; i < 6; i++) begin
            wait_valid(200, n);
            check("result_spacing", 32'(n), 32'd69);
        end

        // Boundary code patterns, applied from the DONE cycle of each frame.
        foreach (vecs[v]) begin
            for (int i = 0; i < 8; i++) begin
                din_a[i] = vecs[v].a;
                din_b[i] = vecs[v].b;
            end
            wait_valid(200, n);
            check("pattern_res_a", 32'(res_a), 32'(vecs[v].exp_a));
            check("pattern_res_b", 32'(res_b), 32'(vecs[v].exp_b));
        end
        for (int i = 0; i < 8; i++) begin
            din_a[i] = 12'h100 + 12'(i);
            din_b[i] = 12'h800 + 12'(i);
        end

        // Drop enable inside the frame for address 2.
        wait_addr(3'd1);
        wait_ncs_low();
        check("drop_frame_addr", 32'(adc_addr), 32'd2);
        enable = 1'b0;
        wait_valid(200, n);
        check("drop_result_addr", 32'(res_addr), 32'd2);
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (ncs !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) bad++;
        end
        check("idle_after_drop", 32'(bad), 32'd0);
        enable = 1'b1;
        wait_valid(200, n);
        check("resume_addr", 32'(res_addr), 32'd3);

        // Reset in the middle of a frame.
        wait_ncs_low();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        exp_addr = 3'd0;
        @(negedge clk);
        check("midrst_ncs_sclk", {30'd0, ncs, adc_sclk}, 32'd3);
        check("midrst_no_valid", 32'(res_valid), 32'd0);
        check("midrst_results", {res_a, res_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_valid(200, n);
        check("after_rst_addr", 32'(res_addr), 32'd0);

        // cfg_rng toggled mid-scan takes effect only at the wrap.
        wait_addr(3'd1);
        cfg_rng = 1'b1;
        wait_addr(3'd5);
        check("rng_held_before_wrap", 32'(rng), 32'd0);
        @(negedge clk);
        check("rng_after_wrap", 32'(rng), 32'd1);
        check("wrap_addr", 32'(adc_addr), 32'd0);
        check("wrap_ncs", 32'(ncs), 32'd1);

        enable = 1'b0;
        repeat (150) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
